// File: rtl/bitwise_gate_pipe.sv
// Two-stage valid/ready pipeline that combines NUM_IN operands with a selectable bitwise gate.
// Optional transfer counter on port xfer_cnt is enabled by defining BITWISE_GATE_CNT_EN.
module bitwise_gate_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_IN = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [2:0]              in_op,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_zero
`ifdef BITWISE_GATE_CNT_EN
   ,
   output logic [15:0]             xfer_cnt
`endif
);

   localparam int unsigned DW = NUM_IN * WIDTH;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_PASS = 3'b110;

   logic             live;
   logic             s1_valid;
   logic [DW-1:0]    s1_data;
   logic [2:0]       s1_op;
   logic             s2_load;
   logic             s1_load;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] and_r;
   logic [WIDTH-1:0] or_r;
   logic [WIDTH-1:0] xor_r;
   logic [WIDTH-1:0] opnd0;

   // Stage 2 takes a new value when empty or draining; stage 1 moves with it.
   assign s2_load  = !out_valid || out_ready;
   assign in_ready = live && (!s1_valid || s2_load);
   assign s1_load  = in_valid && in_ready;

   // live holds in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live <= 1'b0;
      else        live <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_op    <= 3'b000;
      end else if (!s1_valid || s2_load) begin
         s1_valid <= s1_load;
         if (s1_load) begin
            s1_data <= in_data;
            s1_op   <= in_op;
         end
      end
   end

   // Bitwise reductions across every operand held in stage 1
   always_comb begin
      and_r = '1;
      or_r  = '0;
      xor_r = '0;
      opnd0 = s1_data[WIDTH-1:0];
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         and_r = and_r & s1_data[k*WIDTH +: WIDTH];
         or_r  = or_r  | s1_data[k*WIDTH +: WIDTH];
         xor_r = xor_r ^ s1_data[k*WIDTH +: WIDTH];
      end
      case (s1_op)
         OP_AND:  result = and_r;
         OP_OR:   result = or_r;
         OP_XOR:  result = xor_r;
         OP_NAND: result = ~and_r;
         OP_NOR:  result = ~or_r;
         OP_XNOR: result = ~xor_r;
         OP_PASS: result = opnd0;
         default: result = ~opnd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_zero  <= 1'b1;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= result;
            out_zero <= (result == '0);
         end
      end
   end

`ifdef BITWISE_GATE_CNT_EN
   // Saturating count of completed output transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= 16'h0000;
      end else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bitwise_gate_pipe.sv
// Directed and table-driven bench for bitwise_gate_pipe (WIDTH=8, NUM_IN=4).
module tb_bitwise_gate_pipe;

   localparam int unsigned W = 8;
   localparam int unsigned N = 4;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_data;
   logic [2:0]     in_op;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           out_zero;
`ifdef BITWISE_GATE_CNT_EN
   logic [15:0]    xfer_cnt;
`endif

   int n_cmp;
   int n_fail;

   bitwise_gate_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
`ifdef BITWISE_GATE_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] exp;
      logic         ez;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: evaluates each result bit from a per-bit operand count
   function automatic logic [W-1:0] model(input logic [N*W-1:0] d, input logic [2:0] op);
      logic [W-1:0] r;
      int ones;
      for (int b = 0; b < int'(W); b++) begin
         ones = 0;
         for (int k = 0; k < int'(N); k++) ones += int'(d[k*int'(W) + b]);
         case (op)
            3'd0: r[b] = (ones == int'(N));
            3'd1: r[b] = (ones != 0);
            3'd2: r[b] = ones[0];
            3'd3: r[b] = (ones != int'(N));
            3'd4: r[b] = (ones == 0);
            3'd5: r[b] = ~ones[0];
            3'd6: r[b] = d[b];
            default: r[b] = ~d[b];
         endcase
      end
      return r;
   endfunction

   vec_t         vecs[8];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;
   logic [W-1:0] res_a;
   logic [W-1:0] res_b;
   logic [W-1:0] res_c;

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      // operands {FF,F0,3C,AA}: operand 0 is AA
      vecs[0] = '{3'd0, 8'h20, 1'b0};
      vecs[1] = '{3'd1, 8'hFF, 1'b0};
      vecs[2] = '{3'd2, 8'h99, 1'b0};
      vecs[3] = '{3'd3, 8'hDF, 1'b0};
      vecs[4] = '{3'd4, 8'h00, 1'b1};
      vecs[5] = '{3'd5, 8'h66, 1'b0};
      vecs[6] = '{3'd6, 8'hAA, 1'b0};
      vecs[7] = '{3'd7, 8'h55, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_op     = 3'd0;
      out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_zero",  64'(out_zero),  64'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("first_edge_in_ready", 64'(in_ready), 64'd1);

      // All eight ops back to back, two edges of latency each
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            in_valid = 1'b1;
            in_data  = 32'hFFF03CAA;
            in_op    = vecs[i].op;
            chk("ops_in_ready", 64'(in_ready), 64'd1);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (i == 0) chk("ops_latency", 64'(out_valid), 64'd0);
         else begin
            chk("ops_valid", 64'(out_valid), 64'd1);
            chk("ops_data",  64'(out_data),  64'(vecs[i-1].exp));
            chk("ops_zero",  64'(out_zero),  64'(vecs[i-1].ez));
         end
      end
      step();
      chk("ops_drained", 64'(out_valid), 64'd0);

      // Zero flag from an AND of disjoint operands
      in_valid = 1'b1;
      in_data  = 32'hFFFFF00F;
      in_op    = 3'd0;
      step();
      in_valid = 1'b0;
      step();
      chk("zero_valid", 64'(out_valid), 64'd1);
      chk("zero_data",  64'(out_data),  64'h00);
      chk("zero_flag",  64'(out_zero),  64'd1);
      step();

      // Backpressure: three offered, two held, third waits
      res_a = 8'h01;
      res_b = 8'h12;
      res_c = 8'hED;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0F0F0F01;
      in_op     = 3'd0;
      step();
      chk("bp_ready_1", 64'(in_ready), 64'd1);
      in_data = 32'h12000000;
      in_op   = 3'd1;
      step();
      chk("bp_ready_full", 64'(in_ready), 64'd0);
      in_data = 32'h00000012;
      in_op   = 3'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_ready", 64'(in_ready),  64'd0);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_data",  64'(out_data),  64'(res_a));
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_drain", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk("bp_out_b", 64'(out_data), 64'(res_b));
      step();
      chk("bp_out_c_valid", 64'(out_valid), 64'd1);
      chk("bp_out_c", 64'(out_data), 64'(res_c));
      step();
      chk("bp_no_dup", 64'(out_valid), 64'd0);

      // Streaming against the reference model
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = 32'($urandom);
         in_op    = 3'($urandom_range(0, 7));
         chk("str_in_ready", 64'(in_ready), 64'd1);
         exp_q.push_back(model(in_data, in_op));
         step();
         if (i >= 1) begin
            e = exp_q.pop_front();
            chk("str_valid", 64'(out_valid), 64'd1);
            chk("str_data",  64'(out_data),  64'(e));
            chk("str_zero",  64'(out_zero),  64'(e == '0));
         end
      end
      in_valid = 1'b0;
      step();
      e = exp_q.pop_front();
      chk("str_last_data", 64'(out_data), 64'(e));
      step();
      chk("str_empty", 64'(out_valid), 64'd0);

      // Reset with two transactions in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h11111111;
      in_op     = 3'd1;
      step();
      in_data = 32'h22222222;
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready),  64'd0);
      chk("mid_rst_data",  64'(out_data),  64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      chk("mid_rel_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_stale", 64'(out_valid), 64'd0);
         step();
      end

`ifdef BITWISE_GATE_CNT_EN
      chk("cnt_reset", 64'(xfer_cnt), 64'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("cnt_five", 64'(xfer_cnt), 64'd5);
      in_valid = 1'b1;
      for (int i = 0; i < 65540; i++) step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("cnt_sat", 64'(xfer_cnt), 64'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
